// File: rtl/hazard_pkg.sv
// Shared types and constants for the execute-stage hazard controller.
package hazard_pkg;

  localparam int HZ_REG_BITS = 4;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_WB  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  typedef struct packed {
    logic                   valid;
    logic [HZ_REG_BITS-1:0] rd;
    logic                   regWrite;
    logic                   memToReg;
  } stage_info_t;

endpackage

// File: rtl/hazard_fwd_select.sv
// Per-operand forwarding mux select: picks the youngest in-flight producer of the
// Execute source register, never forwarding the program-counter index.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int PC_REG = 15
) (
  input  logic [HZ_REG_BITS-1:0] i_rs,
  input  logic                   i_use,
  input  stage_info_t            i_m,
  input  stage_info_t            i_w,
  output logic [1:0]             o_sel
);

  localparam logic [HZ_REG_BITS-1:0] LP_PC = HZ_REG_BITS'(PC_REG);

  logic w_src_ok;
  logic w_hit_m;
  logic w_hit_w;
  logic w_unused;

  assign w_src_ok = i_use && (i_rs != LP_PC);
  assign w_hit_m  = w_src_ok && i_m.valid && i_m.regWrite && (i_m.rd == i_rs);
  assign w_hit_w  = w_src_ok && i_w.valid && i_w.regWrite && (i_w.rd == i_rs);

  // Load flag is irrelevant here: by M the load data is already on forwardM.
  assign w_unused = i_m.memToReg ^ i_w.memToReg;

  always_comb begin
    o_sel = FWD_REG;
    if (w_hit_m) begin
      o_sel = FWD_MEM;
    end else if (w_hit_w) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Execute-stage hazard controller: shadow E/M/W metadata pipeline, forwarding
// selects, load-use detection, stall/flush strobes and a saturating stall counter.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int REG_BITS  = HZ_REG_BITS,
  parameter int PC_REG    = 15,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_BITS-1:0]  rs1D,
  input  logic [REG_BITS-1:0]  rs2D,
  input  logic                 use1D,
  input  logic                 use2D,
  input  logic [REG_BITS-1:0]  rdD,
  input  logic                 regWriteD,
  input  logic                 memToRegD,
  input  logic                 validD,
  input  logic                 branchTakenE,
  output logic [1:0]           data1ForwardSelector,
  output logic [1:0]           data2ForwardSelector,
  output logic                 stallF,
  output logic                 stallD,
  output logic                 flushD,
  output logic                 flushE,
  output logic [CNT_WIDTH-1:0] stallCount
);

  localparam logic [REG_BITS-1:0] LP_PC = REG_BITS'(PC_REG);

  stage_info_t         r_e;
  stage_info_t         r_m;
  stage_info_t         r_w;
  logic [REG_BITS-1:0] r_e_rs1;
  logic [REG_BITS-1:0] r_e_rs2;
  logic                r_e_use1;
  logic                r_e_use2;
  logic [CNT_WIDTH-1:0] r_stall_count;

  stage_info_t         w_e_next;
  logic [REG_BITS-1:0] w_e_rs1_next;
  logic [REG_BITS-1:0] w_e_rs2_next;
  logic                w_e_use1_next;
  logic                w_e_use2_next;
  logic                w_src_match;
  logic                w_load_use;
  logic                w_bubble;
  logic                w_stall;

  // A load in E whose result the Decode instruction needs cannot be forwarded in time.
  assign w_src_match = (use1D && (rs1D == r_e.rd)) || (use2D && (rs2D == r_e.rd));
  assign w_load_use  = r_e.valid && r_e.memToReg && r_e.regWrite && validD &&
                       w_src_match && (r_e.rd != LP_PC);

  // A taken branch squashes the would-be stalled instruction, so it wins over the stall.
  assign w_stall  = w_load_use && !branchTakenE;
  assign w_bubble = w_load_use || branchTakenE;

  assign stallF     = w_stall;
  assign stallD     = w_stall;
  assign flushD     = branchTakenE;
  assign flushE     = w_bubble;
  assign stallCount = r_stall_count;

  always_comb begin
    w_e_next      = '0;
    w_e_rs1_next  = '0;
    w_e_rs2_next  = '0;
    w_e_use1_next = 1'b0;
    w_e_use2_next = 1'b0;
    if (!w_bubble) begin
      w_e_next.valid    = validD;
      w_e_next.rd       = rdD;
      w_e_next.regWrite = regWriteD;
      w_e_next.memToReg = memToRegD;
      w_e_rs1_next      = rs1D;
      w_e_rs2_next      = rs2D;
      w_e_use1_next     = use1D;
      w_e_use2_next     = use2D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e      <= '0;
      r_m      <= '0;
      r_w      <= '0;
      r_e_rs1  <= '0;
      r_e_rs2  <= '0;
      r_e_use1 <= 1'b0;
      r_e_use2 <= 1'b0;
    end else begin
      r_e      <= w_e_next;
      r_m      <= r_e;
      r_w      <= r_m;
      r_e_rs1  <= w_e_rs1_next;
      r_e_rs2  <= w_e_rs2_next;
      r_e_use1 <= w_e_use1_next;
      r_e_use2 <= w_e_use2_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != {CNT_WIDTH{1'b1}})) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  fwd_select #(
    .PC_REG (PC_REG)
  ) u_fwd1 (
    .i_rs  (r_e_rs1),
    .i_use (r_e_use1),
    .i_m   (r_m),
    .i_w   (r_w),
    .o_sel (data1ForwardSelector)
  );

  fwd_select #(
    .PC_REG (PC_REG)
  ) u_fwd2 (
    .i_rs  (r_e_rs2),
    .i_use (r_e_use2),
    .i_m   (r_m),
    .i_w   (r_w),
    .o_sel (data2ForwardSelector)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: forwarding distances, priority,
// load-use stall, branch override, PC exclusion, counter saturation and async reset.
module tb_hazard_controller;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    rs1D, rs2D, rdD;
  logic          use1D, use2D, regWriteD, memToRegD, validD, branchTakenE;
  logic [1:0]    sel1, sel2;
  logic          stallF, stallD, flushD, flushE;
  logic [CW-1:0] stallCount;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            exp_cnt  = 0;
  logic [3:0]    exp_q[$];
  logic [3:0]    exp_v;
  logic [3:0]    got_v;

  hazard_controller #(
    .REG_BITS  (4),
    .PC_REG    (15),
    .CNT_WIDTH (CW)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .rs1D                 (rs1D),
    .rs2D                 (rs2D),
    .use1D                (use1D),
    .use2D                (use2D),
    .rdD                  (rdD),
    .regWriteD            (regWriteD),
    .memToRegD            (memToRegD),
    .validD               (validD),
    .branchTakenE         (branchTakenE),
    .data1ForwardSelector (sel1),
    .data2ForwardSelector (sel2),
    .stallF               (stallF),
    .stallD               (stallD),
    .flushD               (flushD),
    .flushE               (flushE),
    .stallCount           (stallCount)
  );

  always #5 clk = ~clk;

  task automatic set_d(input logic [3:0] rs1, input logic [3:0] rs2, input logic u1,
                       input logic u2, input logic [3:0] rd, input logic rw,
                       input logic mtr, input logic vd, input logic br);
    rs1D = rs1; rs2D = rs2; use1D = u1; use2D = u2; rdD = rd;
    regWriteD = rw; memToRegD = mtr; validD = vd; branchTakenE = br;
  endtask

  task automatic nop_d();
    set_d(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop_d();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_d(4'd2, 4'd2, 1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({sel1, sel2, stallF, stallD, flushD, flushE} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=00000000", {sel1, sel2, stallF, stallD, flushD, flushE});
    end
    n_checks++;
    if (stallCount !== '0) begin
      n_fail++;
      $display("FAIL reset_count got=%0d exp=0", stallCount);
    end
    nop_d();
    #3;
    rst_n = 1'b1;
    exp_cnt = 0;
    drain();
  endtask

  task automatic test_fwd_distance(input int gap, input logic [1:0] exp_sel);
    drain();
    set_d(4'd0, 4'd0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < gap; i++) begin
      set_d(4'd6, 4'd7, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
    end
    set_d(4'd1, 4'd9, 1'b1, 1'b0, 4'd10, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_q.push_back({exp_sel, 2'd0});
    tick();
    nop_d();
    #1;
    exp_v = exp_q.pop_front();
    got_v = {sel1, sel2};
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL fwd_gap%0d sels got=%h exp=%h", gap, got_v, exp_v);
    end
  endtask

  task automatic test_mem_priority();
    drain();
    set_d(4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    set_d(4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    set_d(4'd3, 4'd3, 1'b1, 1'b1, 4'd11, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_q.push_back({2'd2, 2'd2});
    tick();
    nop_d();
    #1;
    exp_v = exp_q.pop_front();
    got_v = {sel1, sel2};
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL mem_priority sels got=%h exp=%h", got_v, exp_v);
    end
  endtask

  task automatic test_load_use();
    drain();
    set_d(4'd0, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_d(4'd4, 4'd2, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    n_checks++;
    if ({stallF, stallD, flushD, flushE} !== 4'b1101) begin
      n_fail++;
      $display("FAIL load_use_strobes got=%b exp=1101", {stallF, stallD, flushD, flushE});
    end
    n_checks++;
    if (stallCount !== CW'(exp_cnt)) begin
      n_fail++;
      $display("FAIL load_use_count_before got=%0d exp=%0d", stallCount, exp_cnt);
    end
    exp_q.push_back({2'd0, 2'd1});
    tick();
    exp_cnt++;
    #1;
    n_checks++;
    if ({stallF, stallD, flushD, flushE} !== 4'b0000) begin
      n_fail++;
      $display("FAIL load_use_release got=%b exp=0000", {stallF, stallD, flushD, flushE});
    end
    n_checks++;
    if (stallCount !== CW'(exp_cnt)) begin
      n_fail++;
      $display("FAIL load_use_count_after got=%0d exp=%0d", stallCount, exp_cnt);
    end
    n_checks++;
    if ({sel1, sel2} !== 4'h0) begin
      n_fail++;
      $display("FAIL bubble_sels got=%h exp=0", {sel1, sel2});
    end
    tick();
    nop_d();
    #1;
    exp_v = exp_q.pop_front();
    got_v = {sel1, sel2};
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL load_use_consumer_sels got=%h exp=%h", got_v, exp_v);
    end
  endtask

  task automatic test_branch_override();
    drain();
    set_d(4'd0, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_d(4'd2, 4'd0, 1'b1, 1'b0, 4'd6, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    n_checks++;
    if ({stallF, stallD, flushD, flushE} !== 4'b0011) begin
      n_fail++;
      $display("FAIL branch_override_strobes got=%b exp=0011", {stallF, stallD, flushD, flushE});
    end
    tick();
    nop_d();
    #1;
    n_checks++;
    if (stallCount !== CW'(exp_cnt)) begin
      n_fail++;
      $display("FAIL branch_override_count got=%0d exp=%0d", stallCount, exp_cnt);
    end
    n_checks++;
    if ({stallF, stallD, flushD, flushE} !== 4'b0000) begin
      n_fail++;
      $display("FAIL branch_after_strobes got=%b exp=0000", {stallF, stallD, flushD, flushE});
    end
  endtask

  task automatic test_pc_reg();
    drain();
    set_d(4'd0, 4'd0, 1'b0, 1'b0, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    set_d(4'd15, 4'd15, 1'b1, 1'b1, 4'd12, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_q.push_back({2'd0, 2'd0});
    tick();
    nop_d();
    #1;
    exp_v = exp_q.pop_front();
    got_v = {sel1, sel2};
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL pc_no_forward sels got=%h exp=%h", got_v, exp_v);
    end
    drain();
    set_d(4'd0, 4'd0, 1'b0, 1'b0, 4'd15, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_d(4'd15, 4'd0, 1'b1, 1'b0, 4'd12, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    n_checks++;
    if ({stallF, stallD, flushD, flushE} !== 4'b0000) begin
      n_fail++;
      $display("FAIL pc_load_no_stall got=%b exp=0000", {stallF, stallD, flushD, flushE});
    end
    tick();
    nop_d();
    #1;
    n_checks++;
    if (stallCount !== CW'(exp_cnt)) begin
      n_fail++;
      $display("FAIL pc_load_count got=%0d exp=%0d", stallCount, exp_cnt);
    end
  endtask

  task automatic test_saturation();
    drain();
    while (exp_cnt < (1 << CW) - 1) begin
      set_d(4'd0, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      set_d(4'(($urandom_range(0, 1) != 0) ? 2 : 7), 4'd2, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      exp_cnt++;
    end
    nop_d();
    #1;
    n_checks++;
    if (stallCount !== CW'(exp_cnt)) begin
      n_fail++;
      $display("FAIL sat_reach got=%0d exp=%0d", stallCount, exp_cnt);
    end
    set_d(4'd0, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_d(4'd2, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    n_checks++;
    if ({stallF, stallD, flushD, flushE} !== 4'b1101) begin
      n_fail++;
      $display("FAIL sat_stall_strobes got=%b exp=1101", {stallF, stallD, flushD, flushE});
    end
    tick();
    nop_d();
    #1;
    n_checks++;
    if (stallCount !== {CW{1'b1}}) begin
      n_fail++;
      $display("FAIL sat_hold got=%0d exp=%0d", stallCount, (1 << CW) - 1);
    end
  endtask

  task automatic test_reset_mid_stall();
    drain();
    set_d(4'd0, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_d(4'd0, 4'd2, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    n_checks++;
    if ({stallF, stallD, flushE} !== 3'b111) begin
      n_fail++;
      $display("FAIL midstall_pre got=%b exp=111", {stallF, stallD, flushE});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({sel1, sel2, stallF, stallD, flushD, flushE} !== 8'h00) begin
      n_fail++;
      $display("FAIL midstall_async_outputs got=%b exp=00000000", {sel1, sel2, stallF, stallD, flushD, flushE});
    end
    n_checks++;
    if (stallCount !== '0) begin
      n_fail++;
      $display("FAIL midstall_async_count got=%0d exp=0", stallCount);
    end
    tick();
    n_checks++;
    if ({stallF, stallD, flushE, stallCount} !== {3'b000, {CW{1'b0}}}) begin
      n_fail++;
      $display("FAIL midstall_held got=%b cnt=%0d exp=000 cnt=0", {stallF, stallD, flushE}, stallCount);
    end
    #2;
    rst_n = 1'b1;
    exp_cnt = 0;
    drain();
  endtask

  initial begin
    rst_n = 1'b0;
    nop_d();
    test_reset();
    test_fwd_distance(0, 2'd2);
    test_fwd_distance(1, 2'd1);
    test_fwd_distance(2, 2'd0);
    test_mem_priority();
    test_load_use();
    test_branch_override();
    test_pc_reg();
    test_saturation();
    test_reset_mid_stall();
    test_load_use();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
